psu_multirail_sequencer: RTL and testbench
==========================================

// Module: psu_multirail_sequencer
// PURPOSE
//   Generalised adiabatic PSU switch sequencer: drives up to 4 trapezoidal rails. Each rail is a one-hot
//   tap-select bus of STEPS+1 switches. Rail r lags rail 0 by r quarter-periods. Adds a programmable
//   per-step dwell, run/stop control with clean parking at a period boundary, and status strobes.
//   Sits between the test controller and the rail switch banks; hold_end feeds the array read/write enables.
// PARAMETERS
//   STEPS  8  taps per ramp (>=2); each rail has STEPS+1 taps, tap 0 = ground, tap STEPS = full rail
//   RAILS  2  number of rails driven (1..4)
//   DW     4  width of dwell input
// PORTS
//   clk         in   1                 clock
//   rst         in   1                 synchronous reset, active-high
//   en          in   1                 run request, level
//   dwell       in   DW                cycles per step minus 1
//   tap         out  RAILS*(STEPS+1)   rail r one-hot tap select in [r*(STEPS+1) +: STEPS+1]
//   hold_end    out  RAILS             1-cycle strobe: last cycle of rail r high-hold
//   cycle_done  out  1                 1-cycle strobe: last cycle of a full 4-phase period
//   busy        out  1                 high while in RUN
// BEHAVIOUR
// - State registers: mode {IDLE, RUN}; phase 0..3; step s 0..STEPS-1; dwell down-counter dc; dwell_q.
// - All outputs decode from state registers only. No combinational input-to-output path.
// - Reset, and IDLE, hold: phase=3, s=STEPS-1, dc=0, dwell_q=0.
//   Reset outputs: busy=0, hold_end=0, cycle_done=0, tap = park pattern.
// - Tap decode per rail r, with rel=(phase-r) mod 4:
//     rel0 (ramp up)   -> tap s+1
//     rel1 (high)      -> tap STEPS
//     rel2 (ramp down) -> tap STEPS-1-s
//     rel3 (low)       -> tap 0
//   Exactly one tap is high per rail in every cycle, including reset.
// - Park pattern (IDLE decode): rails 0,1 at tap 0; rails 2,3 at tap STEPS.
//   The first RUN cycle moves each rail by at most one tap.
// - IDLE with en=1: next cycle is RUN, phase 0, s=0, dwell_q<=dwell, dc<=dwell. Start latency = 1 clock.
//   IDLE with en=0: state holds.
// - RUN advancement:
//     dc!=0 -> dc decrements
//     dc==0 -> s increments and dc<=dwell_q
//     s==STEPS-1 and dc==0 -> s<=0 and phase increments
//   Each tap therefore holds dwell_q+1 cycles. Period = 4*STEPS*(dwell_q+1).
// - Period end (RUN, phase 3, s=STEPS-1, dc==0):
//     cycle_done=1
//     en=1 -> next cycle phase 0, s=0, dwell_q<=dwell (no idle bubble)
//     en=0 -> next cycle IDLE; taps unchanged, because the park pattern equals the period-end decode
// - dwell is sampled only at period start. Mid-period dwell changes take effect at the next phase 0.
//   Ramps within one period are always symmetric.
// - en deassertion mid-period: the period completes, then the block parks. Stop is never mid-ramp.
// - hold_end[r] = RUN & phase==(r+1)mod 4 & s==STEPS-1 & dc==0. Never asserted in IDLE.
// - busy = (mode==RUN). It falls on the cycle after the final cycle_done.
// - rst mid-operation: the next cycle is IDLE/park pattern regardless of phase.
//   This is a non-adiabatic jump, allowed for fault recovery only. Strobes are 0 that cycle.
// - dwell=0: full-speed stepping with one cycle per tap, and dc stays 0.
//   dwell=2^DW-1: 2^DW cycles per tap; no overflow.
// TESTING
// 1. STEPS=8,RAILS=2, rst=1 -> busy=0, tap[8:0]=9'h001, tap[17:9]=9'h001, hold_end=0, cycle_done=0.
// 2. en=1 from cycle 0, dwell=0 -> rail0 taps 1..8 in cycles 1-8, tap 8 in cycles 9-16, 7..0 in 17-24,
//    0 in 25-32; hold_end[0]@16, hold_end[1]@24, cycle_done@32, phase 0 s=0 @33.
// 3. dwell=2 -> each tap held 3 cycles, cycle_done @96. dwell set to 0 @40 -> no change until cycle 97.
// 4. en dropped @10 -> period completes, cycle_done@32, busy=0 @33, taps equal park pattern, no further strobes.
// 5. RAILS=4 -> park has rails 2,3 at tap 8. Rst mid-ramp @20 -> park pattern @21, busy=0.
//    Restart @22 produces a normal period.
// 6. Random en/dwell/rst, 10k cycles -> every rail one-hot every cycle; each tap change is +-1 except after rst.
//    Period length = 4*STEPS*(dwell_q+1).

Source files
------------

// File: rtl/psu_multirail_sequencer.sv
// rtl/psu_multirail_sequencer.sv - multi-rail trapezoidal tap sequencer with dwell and clean park
module psu_multirail_sequencer #(
    parameter int STEPS = 8,
    parameter int RAILS = 2,
    parameter int DW    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [DW-1:0]                dwell,
    output logic [RAILS*(STEPS+1)-1:0]   tap,
    output logic [RAILS-1:0]             hold_end,
    output logic                         cycle_done,
    output logic                         busy
);

    localparam int SW = $clog2(STEPS);
    localparam int TW = $clog2(STEPS + 1);
    localparam int NT = STEPS + 1;
    localparam logic [SW-1:0] S_LAST = SW'(STEPS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mode_t;

    mode_t         mode_q, mode_d;
    logic [1:0]    phase_q, phase_d;
    logic [SW-1:0] step_q, step_d;
    logic [DW-1:0] dc_q, dc_d;
    logic [DW-1:0] dwell_q, dwell_d;

    logic running;
    logic step_end;
    logic period_end;

    assign running    = (mode_q == RUN);
    assign step_end   = running && (step_q == S_LAST) && (dc_q == '0);
    assign period_end = step_end && (phase_q == 2'd3);

    // One-hot tap for a rail lagging rail 0 by 'lag' quarter-periods.
    function automatic logic [NT-1:0] rail_tap(input logic [1:0] ph,
                                               input logic [SW-1:0] st,
                                               input logic [1:0] lag);
        logic [1:0]    rel;
        logic [TW-1:0] idx;
        rel = ph - lag;
        case (rel)
            2'd0:    idx = TW'(st) + TW'(1);
            2'd1:    idx = TW'(STEPS);
            2'd2:    idx = TW'(S_LAST - st);
            default: idx = '0;
        endcase
        return NT'(1) << idx;
    endfunction

    // State register; reset lands on the period-end state so taps decode to the park pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= IDLE;
            phase_q <= 2'd3;
            step_q  <= S_LAST;
            dc_q    <= '0;
            dwell_q <= '0;
        end else begin
            mode_q  <= mode_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            dc_q    <= dc_d;
            dwell_q <= dwell_d;
        end
    end

    // Next-state: dwell countdown, step/phase advance, restart or park at period end.
    always_comb begin
        mode_d  = mode_q;
        phase_d = phase_q;
        step_d  = step_q;
        dc_d    = dc_q;
        dwell_d = dwell_q;
        case (mode_q)
            IDLE: begin
                if (en) begin
                    mode_d  = RUN;
                    phase_d = 2'd0;
                    step_d  = '0;
                    dwell_d = dwell;
                    dc_d    = dwell;
                end
            end
            RUN: begin
                if (dc_q != '0) begin
                    dc_d = dc_q - DW'(1);
                end else if (step_q != S_LAST) begin
                    step_d = step_q + SW'(1);
                    dc_d   = dwell_q;
                end else if (phase_q != 2'd3) begin
                    step_d  = '0;
                    phase_d = phase_q + 2'd1;
                    dc_d    = dwell_q;
                end else if (en) begin
                    // Back-to-back period: dwell is re-sampled only here.
                    step_d  = '0;
                    phase_d = 2'd0;
                    dwell_d = dwell;
                    dc_d    = dwell;
                end else begin
                    // Park: state already decodes to the park pattern, so taps do not move.
                    mode_d  = IDLE;
                    phase_d = 2'd3;
                    step_d  = S_LAST;
                    dc_d    = '0;
                    dwell_d = '0;
                end
            end
            default: mode_d = IDLE;
        endcase
    end

    // Output decode from registered state only; IDLE state decodes to the park pattern.
    always_comb begin
        tap      = '0;
        hold_end = '0;
        for (int r = 0; r < RAILS; r++) begin
            tap[r*NT +: NT] = rail_tap(phase_q, step_q, 2'(r));
            hold_end[r]     = step_end && (phase_q == 2'(r + 1));
        end
        cycle_done = period_end;
        busy       = running;
    end

endmodule

// File: tb/tb_psu_multirail_sequencer.sv
// tb/tb_psu_multirail_sequencer.sv - scoreboard bench for psu_multirail_sequencer
module tb_psu_multirail_sequencer;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  dwell;
    logic [35:0] tap;
    logic [3:0]  hold_end;
    logic        cycle_done;
    logic        busy;

    typedef struct {
        int          cyc;
        logic [35:0] tap;
        logic [3:0]  he;
        logic        cd;
        logic        busy;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_on = 0;

    localparam logic [35:0] PARK = {9'h100, 9'h100, 9'h001, 9'h001};

    psu_multirail_sequencer #(.STEPS(8), .RAILS(4), .DW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dwell      (dwell),
        .tap        (tap),
        .hold_end   (hold_end),
        .cycle_done (cycle_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs k cycles after the first RUN cycle, with constant dwell d.
    function automatic exp_t model_run(input int c, input int k, input int d, input string nm);
        exp_t e;
        int per, u, j, ph, s, rel, idx;
        logic last;
        per = 32 * (d + 1);
        u   = k % per;
        j   = u / (d + 1);
        ph  = j / 8;
        s   = j % 8;
        last = ((u % (d + 1)) == d) && (s == 7);
        e.cyc = c; e.tap = '0; e.he = '0; e.nm = nm;
        for (int r = 0; r < 4; r++) begin
            rel = (ph - r + 4) % 4;
            case (rel)
                0:       idx = s + 1;
                1:       idx = 8;
                2:       idx = 7 - s;
                default: idx = 0;
            endcase
            e.tap[r*9 +: 9] = 9'(1) << idx;
            e.he[r] = last && (ph == ((r + 1) % 4));
        end
        e.cd   = last && (ph == 3);
        e.busy = 1'b1;
        return e;
    endfunction

    task automatic push_run(input int b, input int from, input int to, input int k0, input int d, input string nm);
        for (int c = from; c <= to; c++) q.push_back(model_run(b + c, c - k0, d, nm));
    endtask

    task automatic push_park(input int b, input int from, input int to, input string nm);
        exp_t e;
        for (int c = from; c <= to; c++) begin
            e.cyc = b + c; e.tap = PARK; e.he = '0; e.cd = 1'b0; e.busy = 1'b0; e.nm = nm;
            q.push_back(e);
        end
    endtask

    task automatic run_scn(input int len, input int d0, input int d1, input int dchg,
                           input int en_off, input int rst_at);
        for (int n = 0; n < len; n++) begin
            rst   = (n == rst_at);
            en    = (n < en_off);
            dwell = (n >= dchg) ? 4'(d1) : 4'(d0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        en  = 1'b0;
    endtask

    // Monitor: one-hot per rail every cycle, and scoreboard pop for due entries.
    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            for (int r = 0; r < 4; r++) begin
                checks++;
                if (!$onehot(tap[r*9 +: 9])) begin
                    failures++;
                    $display("FAIL onehot rail%0d cyc=%0d got=%h required one-hot", r, cyc, tap[r*9 +: 9]);
                end
            end
        end
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || tap !== e.tap || hold_end !== e.he || cycle_done !== e.cd || busy !== e.busy) begin
                failures++;
                $display("FAIL %s cyc=%0d(exp@%0d) got tap=%h he=%b cd=%b busy=%b required tap=%h he=%b cd=%b busy=%b",
                         e.nm, cyc, e.cyc, tap, hold_end, cycle_done, busy, e.tap, e.he, e.cd, e.busy);
            end
        end
    end

    initial begin
        int b;
        rst = 1'b1; en = 1'b0; dwell = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state: park pattern, no strobes, even with en high during reset.
        b = cyc;
        push_park(b, 0, 3, "reset");
        mon_on = 1'b1;
        en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // dwell=0, back-to-back periods, then stop mid second period.
        b = cyc;
        push_run(b, 1, 32, 1, 0, "d0_p1");
        push_run(b, 33, 64, 33, 0, "d0_p2");
        push_park(b, 65, 69, "d0_park");
        run_scn(70, 0, 0, 1000, 34, -1);

        // en dropped at 10: period completes, parks at 33.
        b = cyc;
        push_run(b, 1, 32, 1, 0, "stop10");
        push_park(b, 33, 39, "stop10_park");
        run_scn(40, 0, 0, 1000, 10, -1);

        // dwell=2 with mid-period change to 0 at 40, effective at 97.
        b = cyc;
        push_run(b, 1, 96, 1, 2, "dw2");
        push_run(b, 97, 128, 97, 0, "dw2to0");
        push_park(b, 129, 134, "dw2_park");
        run_scn(135, 2, 0, 40, 100, -1);

        // Maximum dwell: 16 cycles per tap.
        b = cyc;
        push_run(b, 1, 512, 1, 15, "dwmax");
        push_park(b, 513, 519, "dwmax_park");
        run_scn(520, 15, 15, 1000, 5, -1);

        // Reset mid-ramp at 20, restart at 22.
        b = cyc;
        push_run(b, 1, 20, 1, 0, "pre_rst");
        push_park(b, 21, 21, "rst_mid");
        push_run(b, 22, 53, 22, 0, "restart");
        push_park(b, 54, 59, "restart_park");
        run_scn(60, 0, 0, 1000, 23, 20);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL leftover got=%0d pending required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
